// File: rtl/vec_requant_pkg.sv
// vec_requant_pkg: shared FSM states, int8 saturation bounds and product width for the requant datapath.
package vec_requant_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    localparam int sat_min = -128;
    localparam int sat_max = 127;
    localparam int mult_width = 16;
    function automatic int prod_width(input int acc_width);
        return acc_width + mult_width;
    endfunction
endpackage

// File: rtl/requant_lane.sv
// requant_lane: one element; stage 1 registers acc*mult, stage 2 registers the rounded, shifted, saturated int8.
module requant_lane
    import vec_requant_pkg::*;
#(
    parameter int AccWidth = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         en,
    input  logic signed [AccWidth-1:0]   acc,
    input  logic signed [mult_width-1:0] mult,
    input  logic [4:0]                   shift,
    output logic signed [7:0]            y
);
    localparam int pw = prod_width(AccWidth);
    localparam logic signed [pw:0] hi = (pw+1)'(sat_max);
    localparam logic signed [pw:0] lo = (pw+1)'(sat_min);
    logic signed [pw-1:0] p;
    logic signed [pw:0]   rnd, sum, sh;
    logic signed [7:0]    y_next;
    // one extra bit so adding the half-LSB can never wrap the product
    always_comb begin
        rnd    = shift == 5'd0 ? '0 : (pw+1)'(1) << (shift - 5'd1);
        sum    = (pw+1)'(p) + rnd;
        sh     = sum >>> shift;
        y_next = sh > hi ? 8'(sat_max) : sh < lo ? 8'(sat_min) : sh[7:0];
    end
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            p <= '0;
            y <= '0;
        end else if (en) begin
            p <= pw'(acc) * pw'(mult);
            y <= y_next;
        end
    end
endmodule

// File: rtl/vec_requant.sv
// vec_requant: streams a vector chunk by chunk through WorkingRegs requant lanes,
// stalling the whole pipeline on downstream backpressure and pulsing when the vector is written.
module vec_requant
    import vec_requant_pkg::*;
#(
    parameter int InVecLength = 8,
    parameter int WorkingRegs = 4,
    parameter int AccWidth    = 32
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  in_data_ready,
    input  logic [WorkingRegs-1:0][AccWidth-1:0]  in_data,
    output logic                                  req_chunk_in,
    input  logic signed [mult_width-1:0]          scale_mult,
    input  logic [4:0]                            scale_shift,
    input  logic                                  out_ready,
    output logic [WorkingRegs-1:0][7:0]           write_out_data,
    output logic                                  req_chunk_out,
    output logic                                  out_vector_valid
);
    localparam int chunks = InVecLength / WorkingRegs;
    localparam int cw = $clog2(chunks + 1);
    state_t state, next;
    logic [cw-1:0] cnt;
    logic v1, v2, last;
    logic signed [mult_width-1:0] mult_q;
    logic [4:0] shift_q;
    assign last          = cnt == cw'(chunks - 1);
    assign req_chunk_out = v2 && out_ready;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            cnt     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            mult_q  <= '0;
            shift_q <= '0;
        end else begin
            state <= next;
            if (state == IDLE && in_data_ready) begin
                mult_q  <= scale_mult;
                shift_q <= scale_shift;
            end
            if (out_ready) begin
                v1 <= req_chunk_in;
                v2 <= v1;
            end
            if (req_chunk_in) cnt <= last ? '0 : cnt + cw'(1);
        end
    end
    // the last chunk leaves when stage 2 holds it and nothing follows in stage 1
    always_comb begin
        next             = state;
        req_chunk_in     = 1'b0;
        out_vector_valid = 1'b0;
        case (state)
            IDLE:    next = in_data_ready ? STREAM : IDLE;
            STREAM: begin
                req_chunk_in = out_ready;
                next         = out_ready && last ? DRAIN : STREAM;
            end
            DRAIN:   next = out_ready && v2 && !v1 ? DONE : DRAIN;
            DONE: begin
                out_vector_valid = 1'b1;
                next             = IDLE;
            end
            default: next = IDLE;
        endcase
    end
    for (genvar i = 0; i < WorkingRegs; i++) begin : g_lane
        requant_lane #(.AccWidth(AccWidth)) u_lane (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .en     (out_ready),
            .acc    (in_data[i]),
            .mult   (mult_q),
            .shift  (shift_q),
            .y      (write_out_data[i])
        );
    end
endmodule

// File: tb/tb_vec_requant.sv
// tb_vec_requant: table vectors plus randomized vectors against an arithmetic model of the requant rule.
module tb_vec_requant;
    localparam int L = 8, W = 4, A = 32, NC = L / W;
    logic clk_in = 0, rst_in = 0, in_data_ready = 0, out_ready = 0;
    logic [W-1:0][A-1:0] in_data = '0;
    logic signed [15:0] scale_mult = '0;
    logic [4:0] scale_shift = '0;
    logic req_chunk_in, req_chunk_out, out_vector_valid;
    logic [W-1:0][7:0] write_out_data;
    int n_cmp = 0, n_bad = 0;
    int cur_acc[L], cur_exp[L];
    typedef struct { int m; int s; int acc[L]; int exp[L]; } vec_t;
    vec_t tbl[4];

    vec_requant #(.InVecLength(L), .WorkingRegs(W), .AccWidth(A)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .in_data_ready(in_data_ready), .in_data(in_data),
        .req_chunk_in(req_chunk_in), .scale_mult(scale_mult), .scale_shift(scale_shift),
        .out_ready(out_ready), .write_out_data(write_out_data), .req_chunk_out(req_chunk_out),
        .out_vector_valid(out_vector_valid)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_q(input int a, input int m, input int s);
        longint p;
        p = longint'(a) * longint'(m);
        if (s > 0) p = p + (longint'(1) <<< (s - 1));
        p = p >>> s;
        return p > 127 ? 127 : p < -128 ? -128 : int'(p);
    endfunction

    task automatic load_tbl(input int t);
        for (int i = 0; i < L; i++) begin
            cur_acc[i] = tbl[t].acc[i];
            cur_exp[i] = tbl[t].exp[i];
        end
    endtask

    task automatic load_rand(input int m, input int s);
        for (int i = 0; i < L; i++) begin
            cur_acc[i] = $urandom_range(0, 1) == 1 ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
            cur_exp[i] = ref_q(cur_acc[i], m, s);
        end
    endtask

    function automatic logic [W*8-1:0] exp_chunk(input int c);
        logic [W*8-1:0] e;
        for (int i = 0; i < W; i++) e[i*8 +: 8] = 8'(cur_exp[c*W+i]);
        return e;
    endfunction

    // mode 0: no backpressure (latency checked); 1: random backpressure; 2: 3-cycle stall after first output
    task automatic run_vector(input int m, input int s, input int mode, input bit hold, input int nm, input int ns);
        int rd = 0, wr = 0, cyc = 0, stall = 0, ci;
        bit done = 0, prev_stall = 0;
        int inq[$];
        logic [W*8-1:0] prev = '0;
        in_data_ready = 1;
        scale_mult = 16'(m);
        scale_shift = 5'(s);
        while (!done && cyc < 300) begin
            @(negedge clk_in);
            if (stall > 0) begin
                out_ready = 0;
                stall--;
            end else out_ready = mode == 1 ? ($urandom_range(0, 9) < 7) : 1'b1;
            for (int i = 0; i < W; i++) in_data[i] = rd < NC ? cur_acc[rd*W+i] : 0;
            #1;
            if (prev_stall) chk("frozen_data", write_out_data, prev);
            if (!out_ready) begin
                chk("stall_req_in", req_chunk_in, 0);
                chk("stall_req_out", req_chunk_out, 0);
            end
            if (req_chunk_in) begin
                rd++;
                inq.push_back(cyc);
                if (rd == 1) begin
                    scale_mult = 16'(nm);
                    scale_shift = 5'(ns);
                    if (!hold) in_data_ready = 0;
                end
            end
            if (req_chunk_out) begin
                chk("chunk_data", write_out_data, wr < NC ? exp_chunk(wr) : '0);
                if (inq.size() == 0) chk("orphan_out", 1, 0);
                else begin
                    ci = inq.pop_front();
                    if (mode == 0) chk("latency", cyc - ci, 2);
                end
                wr++;
                if (mode == 2 && wr == 1) stall = 3;
            end
            if (out_vector_valid) begin
                chk("chunks_before_valid", wr, NC);
                done = 1;
            end
            prev = write_out_data;
            prev_stall = !out_ready;
            cyc++;
        end
        if (!done) chk("vector_timeout", 0, 1);
        chk("chunks_read", rd, NC);
        @(negedge clk_in);
        #1;
        chk("valid_one_cycle", out_vector_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int m1, m2, s, mode;
        logic signed [15:0] r16;
        bit seen;
        tbl[0] = '{256, 8, '{5, -5, 1000, -1000, 0, 127, 128, -129}, '{5, -5, 127, -128, 0, 127, 127, -128}};
        tbl[1] = '{1, 1, '{3, -3, 1, -1, 2, -2, 5, -5}, '{2, -1, 1, 0, 1, -1, 3, -2}};
        tbl[2] = '{-1, 0, '{-128, 127, 128, -127, 0, 1, -1, 2147483647}, '{127, -127, -128, 127, 0, -1, 1, -128}};
        tbl[3] = '{32767, 31, '{2147483647, 32'h80000000, 65536, 0, 1, -1, 100000, -100000},
                   '{127, -128, 1, 0, 0, 0, 2, -2}};
        out_ready = 1;
        repeat (2) @(negedge clk_in);
        #1;
        chk("rst_req_in", req_chunk_in, 0);
        chk("rst_req_out", req_chunk_out, 0);
        chk("rst_valid", out_vector_valid, 0);
        chk("rst_data", write_out_data, 0);
        @(negedge clk_in);
        rst_in = 1;

        for (int t = 0; t < 4; t++) begin
            load_tbl(t);
            run_vector(tbl[t].m, tbl[t].s, 0, 0, int'($urandom), int'($urandom));
        end

        load_tbl(0);
        run_vector(tbl[0].m, tbl[0].s, 2, 0, int'($urandom), int'($urandom));

        // back-to-back: scale changes during the first vector only apply to the second
        m1 = 3; m2 = -7;
        load_rand(m1, 2);
        run_vector(m1, 2, 0, 1, m2, 3);
        load_rand(m2, 3);
        run_vector(m2, 3, 0, 0, int'($urandom), int'($urandom));

        // reset after the first output chunk
        load_tbl(0);
        in_data_ready = 1;
        scale_mult = 16'(tbl[0].m);
        scale_shift = 5'(tbl[0].s);
        seen = 0;
        for (int c = 0, rd = 0; c < 50 && !seen; c++) begin
            @(negedge clk_in);
            out_ready = 1;
            for (int i = 0; i < W; i++) in_data[i] = rd < NC ? cur_acc[rd*W+i] : 0;
            #1;
            if (req_chunk_in) begin
                rd++;
                in_data_ready = 0;
            end
            if (req_chunk_out) seen = 1;
        end
        chk("first_chunk_seen", seen, 1);
        @(posedge clk_in);
        #1;
        rst_in = 0;
        #1;
        chk("arst_req_in", req_chunk_in, 0);
        chk("arst_req_out", req_chunk_out, 0);
        chk("arst_valid", out_vector_valid, 0);
        chk("arst_data", write_out_data, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk_in);
            #1;
            if (out_vector_valid || req_chunk_out) seen = 1;
        end
        chk("no_valid_after_reset", seen, 0);
        load_tbl(1);
        run_vector(tbl[1].m, tbl[1].s, 0, 0, int'($urandom), int'($urandom));

        for (int v = 0; v < 12; v++) begin
            r16 = 16'($urandom);
            m1 = r16;
            s = v < 4 ? int'($urandom_range(0, 31)) : int'($urandom_range(8, 24));
            mode = v % 3 == 0 ? 0 : 1;
            load_rand(m1, s);
            run_vector(m1, s, mode, 0, int'($urandom), int'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
